// File: rtl/digit_argmax.sv
// rtl/digit_argmax.sv - argmax decision stage over one frame of neuron scores
// Optional feature macro: DIGIT_ARGMAX_MARGIN_EN (adds runner-up tracking and m_margin)
module digit_argmax #(
  parameter int N_CLASSES     = 10,
  parameter int DATA_W        = 32,
  parameter bit SIGNED_SCORES = 1'b0,
  localparam int DW           = $clog2(N_CLASSES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_score,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_digit,
  output logic [DATA_W-1:0] m_score,
  output logic              m_error
`ifdef DIGIT_ARGMAX_MARGIN_EN
  ,
  output logic [DATA_W-1:0] m_margin
`endif
);

  localparam logic [DW-1:0] LAST_IDX = DW'(N_CLASSES - 1);

  typedef enum logic {COLLECT = 1'b0, RESULT = 1'b1} state_t;

  state_t            state, state_n;
  logic [DW-1:0]     idx;
  logic [DW-1:0]     best_idx, best_idx_n;
  logic [DATA_W-1:0] best, best_n;
  logic              accept, frame_end;
`ifdef DIGIT_ARGMAX_MARGIN_EN
  logic [DATA_W-1:0] runner, runner_n;
`endif

  // Strict greater-than in the configured signedness; ties never win.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_SCORES) return $signed(a) > $signed(b);
    else               return a > b;
  endfunction

  assign accept    = s_valid && s_ready;
  assign frame_end = accept && (s_last || (idx == LAST_IDX));
  assign m_valid   = (state == RESULT);

  // State register; s_ready is registered so it stays low through reset and rises one clock after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= COLLECT;
      s_ready <= 1'b0;
    end else begin
      state   <= state_n;
      s_ready <= (state_n == COLLECT);
    end
  end

  // Next-state: collect until the frame ends, then hold the result until it is taken.
  always_comb begin
    state_n = state;
    case (state)
      COLLECT: if (frame_end) state_n = RESULT;
      RESULT:  if (m_ready)   state_n = COLLECT;
      default: state_n = COLLECT;
    endcase
  end

  // Candidate best/runner-up including the beat currently presented.
  always_comb begin
    best_n     = best;
    best_idx_n = best_idx;
`ifdef DIGIT_ARGMAX_MARGIN_EN
    runner_n   = runner;
`endif
    if (idx == '0) begin
      best_n     = s_score;
      best_idx_n = '0;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_n   = s_score;
`endif
    end else if (gt(s_score, best)) begin
      best_n     = s_score;
      best_idx_n = idx;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner_n   = best;
`endif
    end
`ifdef DIGIT_ARGMAX_MARGIN_EN
    else if (gt(s_score, runner)) begin
      runner_n = s_score;
    end
`endif
  end

  // Datapath: fold accepted beats into the running best, publish on frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      m_digit  <= '0;
      m_score  <= '0;
      m_error  <= 1'b0;
`ifdef DIGIT_ARGMAX_MARGIN_EN
      runner   <= '0;
      m_margin <= '0;
`endif
    end else begin
      if (accept) begin
        best     <= best_n;
        best_idx <= best_idx_n;
`ifdef DIGIT_ARGMAX_MARGIN_EN
        runner   <= runner_n;
`endif
        if (frame_end) begin
          m_digit  <= best_idx_n;
          m_score  <= best_n;
          m_error  <= !(s_last && (idx == LAST_IDX));
`ifdef DIGIT_ARGMAX_MARGIN_EN
          m_margin <= best_n - runner_n;
`endif
        end else begin
          idx <= idx + DW'(1);
        end
      end
      if (m_valid && m_ready) idx <= '0;
    end
  end

endmodule
